cache_fill_fsm: RTL and testbench

//   Reader-side counterpart to the cache storage arrays: on a cache miss, fetches one

---
 rtl/cache_fill_fsm.sv | 149 ++++++++++++++
 tb/tb_cache_fill_fsm.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm
//   Block-fill engine for the cache. On a miss it requests every word of the
//   missing block from a pipelined main memory, one request per cycle. Each
//   returned word is written into the data array, and the tag array is written
//   together with the last word. The pipeline stalls while fsm_busy is high.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   miss_detected   cache reports a miss this cycle
//   miss_address    byte address that missed
//   mem_rd_en       registered read request to memory
//   mem_addr        registered byte address of the request
//   mem_data_valid  memory returns a word this cycle (in request order)
//   mem_data        returned word
//   fsm_busy        fill in progress
//   data_wr_en      data array write strobe (combinational)
//   word_sel        one-hot word enable within the block
//   data_wr         word to write (mem_data passed through)
//   tag_wr_en       tag array write strobe, asserted with the last word
//   fill_done       one-cycle completion pulse, asserted with the last word
module cache_fill_fsm #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned WORDS   = 8,
  parameter int unsigned MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_data_valid,
  input  logic [DATA_W-1:0] mem_data,
  output logic              fsm_busy,
  output logic              data_wr_en,
  output logic [WORDS-1:0]  word_sel,
  output logic [DATA_W-1:0] data_wr,
  output logic              tag_wr_en,
  output logic              fill_done
);

  localparam int unsigned        CW        = $clog2(WORDS) + 1;
  localparam int unsigned        STEP      = DATA_W / 8;
  localparam int unsigned        BLK_BYTES = WORDS * STEP;
  localparam logic [ADDR_W-1:0]  OFF_MASK  = ADDR_W'(BLK_BYTES - 1);
  localparam logic [CW-1:0]      LAST_IDX  = CW'(WORDS - 1);
  localparam logic [CW-1:0]      N_WORDS   = CW'(WORDS);

  // The fill logic itself is latency-agnostic (responses are simply counted),
  // but a zero-latency memory or a single-word block is not a valid setup.
  if (WORDS < 2 || MEM_LAT < 1) begin : g_param_check
    $error("cache_fill_fsm: WORDS must be >= 2 and MEM_LAT >= 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t            r_state,     w_state_nxt;
  logic [CW-1:0]     r_issue_cnt, w_issue_cnt_nxt;
  logic [CW-1:0]     r_recv_cnt,  w_recv_cnt_nxt;
  logic [ADDR_W-1:0] r_base,      w_base_nxt;
  logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
  logic              r_mem_rd_en, w_mem_rd_en_nxt;

  logic [CW-1:0]     w_issue_inc;
  logic [ADDR_W-1:0] w_miss_base;
  logic              w_wr;
  logic              w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_base      <= '0;
      r_mem_addr  <= '0;
      r_mem_rd_en <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_issue_cnt <= w_issue_cnt_nxt;
      r_recv_cnt  <= w_recv_cnt_nxt;
      r_base      <= w_base_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_rd_en <= w_mem_rd_en_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_issue_cnt_nxt = r_issue_cnt;
    w_recv_cnt_nxt  = r_recv_cnt;
    w_base_nxt      = r_base;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_rd_en_nxt = 1'b0;

    w_issue_inc = r_issue_cnt + CW'(1);
    w_miss_base = miss_address & ~OFF_MASK;
    w_wr        = (r_state == FILL) && mem_data_valid;
    w_last      = w_wr && (r_recv_cnt == LAST_IDX);

    data_wr_en = w_wr;
    word_sel   = w_wr ? (WORDS'(1) << r_recv_cnt) : '0;
    data_wr    = mem_data;
    tag_wr_en  = w_last;
    fill_done  = w_last;

    case (r_state)
      IDLE: begin
        if (miss_detected) begin
          w_state_nxt     = FILL;
          w_base_nxt      = w_miss_base;
          w_issue_cnt_nxt = '0;
          w_recv_cnt_nxt  = '0;
          // Request 0 is loaded on the entry edge so the registered request
          // is already on the bus during the first FILL cycle.
          w_mem_rd_en_nxt = 1'b1;
          w_mem_addr_nxt  = w_miss_base;
        end
      end
      FILL: begin
        if (r_mem_rd_en) begin
          w_issue_cnt_nxt = w_issue_inc;
          if (w_issue_inc < N_WORDS) begin
            w_mem_rd_en_nxt = 1'b1;
            w_mem_addr_nxt  = r_base + ADDR_W'(w_issue_inc) * ADDR_W'(STEP);
          end
        end
        if (w_wr) begin
          w_recv_cnt_nxt = r_recv_cnt + CW'(1);
        end
        // A miss on this edge is deliberately not looked at; the cache
        // re-presents it once we are back in IDLE.
        if (w_last) begin
          w_state_nxt     = IDLE;
          w_mem_rd_en_nxt = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign mem_rd_en = r_mem_rd_en;
  assign mem_addr  = r_mem_addr;
  assign fsm_busy  = (r_state == FILL);

endmodule

// File: tb/tb_cache_fill_fsm.sv
module tb_cache_fill_fsm;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned WORDS   = 8;
  localparam int unsigned MEM_LAT = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_data_valid;
  logic [DATA_W-1:0] mem_data;
  logic              fsm_busy;
  logic              data_wr_en;
  logic [WORDS-1:0]  word_sel;
  logic [DATA_W-1:0] data_wr;
  logic              tag_wr_en;
  logic              fill_done;

  always #5 clk = ~clk;

  cache_fill_fsm #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .WORDS  (WORDS),
    .MEM_LAT(MEM_LAT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .miss_detected (miss_detected),
    .miss_address  (miss_address),
    .mem_rd_en     (mem_rd_en),
    .mem_addr      (mem_addr),
    .mem_data_valid(mem_data_valid),
    .mem_data      (mem_data),
    .fsm_busy      (fsm_busy),
    .data_wr_en    (data_wr_en),
    .word_sel      (word_sel),
    .data_wr       (data_wr),
    .tag_wr_en     (tag_wr_en),
    .fill_done     (fill_done)
  );

  // Memory model: a request seen in cycle c returns data ~addr in cycle c+MEM_LAT.
  logic              pv [MEM_LAT];
  logic [DATA_W-1:0] pd [MEM_LAT];
  logic              inj_v;
  logic [DATA_W-1:0] inj_d;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        pv[i] <= 1'b0;
        pd[i] <= '0;
      end
    end else begin
      pv[0] <= mem_rd_en;
      pd[0] <= ~mem_addr;
      for (int i = 1; i < MEM_LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign mem_data_valid = pv[MEM_LAT-1] | inj_v;
  assign mem_data       = inj_v ? inj_d : pd[MEM_LAT-1];

  // Scoreboard
  typedef struct packed {
    logic [WORDS-1:0]  sel;
    logic [DATA_W-1:0] data;
    logic              last;
  } wr_t;

  logic [ADDR_W-1:0] q_req [$];
  wr_t               q_wr  [$];
  int n_chk  = 0;
  int n_pass = 0;
  int n_wr   = 0;
  int n_tag  = 0;
  logic prev_done = 1'b0;
  wr_t               m_w;
  logic [ADDR_W-1:0] m_a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_done) check("busy_after_done", 32'(fsm_busy), 32'd0);
      prev_done <= fill_done;
      if (mem_rd_en) begin
        if (q_req.size() == 0) check("req_unexpected", 32'(mem_rd_en), 32'd0);
        else begin
          m_a = q_req.pop_front();
          check("req_addr", 32'(mem_addr), 32'(m_a));
        end
      end
      if (data_wr_en) begin
        n_wr <= n_wr + 1;
        if (q_wr.size() == 0) check("wr_unexpected", 32'(data_wr_en), 32'd0);
        else begin
          m_w = q_wr.pop_front();
          check("wr_word_sel", 32'(word_sel), 32'(m_w.sel));
          check("wr_data", 32'(data_wr), 32'(m_w.data));
          check("wr_tag", 32'(tag_wr_en), 32'(m_w.last));
          check("wr_done", 32'(fill_done), 32'(m_w.last));
        end
      end else begin
        check("idle_strobes", 32'({word_sel, tag_wr_en, fill_done}), 32'd0);
      end
      if (tag_wr_en) n_tag <= n_tag + 1;
    end
  end

  task automatic push_fill(input logic [ADDR_W-1:0] base);
    logic [ADDR_W-1:0] a;
    wr_t w;
    for (int i = 0; i < WORDS; i++) begin
      a = base + 16'(2 * i);
      q_req.push_back(a);
      w.sel  = WORDS'(1) << i;
      w.data = ~a;
      w.last = (i == WORDS - 1);
      q_wr.push_back(w);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, 32'({mem_rd_en, fsm_busy, data_wr_en, word_sel, tag_wr_en, fill_done}), 32'd0);
    check({name, "_addr"}, 32'(mem_addr), 32'd0);
  endtask

  // Issues a miss, returns at the cycle fill_done was seen (miss left high if hold).
  task automatic run_fill(input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] base,
                          input bit hold);
    bit done = 0;
    push_fill(base);
    @(negedge clk); #1;
    miss_detected = 1'b1;
    miss_address  = addr;
    @(posedge clk); #1;
    check("start_busy", 32'(fsm_busy), 32'd1);
    check("start_rd_en", 32'(mem_rd_en), 32'd1);
    check("start_addr", 32'(mem_addr), 32'(base));
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk); #1;
      if (k == WORDS - 1) check("reqs_consumed", 32'(q_req.size()), 32'd0);
      if (k == WORDS) check("rd_en_stops", 32'(mem_rd_en), 32'd0);
      if (fill_done) begin
        done = 1;
        check("done_cycle", 32'(k), 32'(MEM_LAT + WORDS - 1));
      end else if (hold) begin
        miss_address = addr + 16'(k + 1) * 16'h0110;
      end else begin
        miss_detected = 1'b0;
      end
    end
    if (!done) check("fill_done_timeout", 32'(fill_done), 32'd1);
  endtask

  int t0, w0, start;
  bit seen;

  initial begin
    rst_n         = 1'b0;
    miss_detected = 1'b0;
    miss_address  = '0;
    inj_v         = 1'b0;
    inj_d         = '0;

    repeat (2) @(negedge clk);
    #1 check_all_zero("reset_held");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1 check_all_zero("first_edge");

    // 1: basic fill
    run_fill(16'h1234, 16'h1230, 0);
    check("t1_wr_left", 32'(q_wr.size()), 32'd0);

    // 2: top-of-memory block
    repeat (2) @(negedge clk);
    run_fill(16'hFFFF, 16'hFFF0, 0);
    check("t2_wr_left", 32'(q_wr.size()), 32'd0);

    // 3: miss held high, address moving
    t0 = n_tag;
    run_fill(16'h3456, 16'h3450, 1);
    @(negedge clk); #1 miss_detected = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("t3_busy", 32'(fsm_busy), 32'd0);
    check("t3_req_left", 32'(q_req.size()), 32'd0);
    check("t3_single_tag", 32'(n_tag - t0), 32'd1);

    // 4: stray valid in IDLE
    @(negedge clk); #1;
    inj_d = 16'hBEEF;
    inj_v = 1'b1;
    #1;
    check("t4_wr_en", 32'(data_wr_en), 32'd0);
    check("t4_sel", 32'(word_sel), 32'd0);
    check("t4_tag", 32'(tag_wr_en), 32'd0);
    check("t4_data_pass", 32'(data_wr), 32'h0000BEEF);
    @(negedge clk); #1 inj_v = 1'b0;

    // 5: reset after three words
    push_fill(16'h0100);
    start = n_wr;
    t0    = n_tag;
    @(negedge clk); #1;
    miss_detected = 1'b1;
    miss_address  = 16'h0104;
    @(negedge clk); #1 miss_detected = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk); #1;
      if (n_wr == start + 3) seen = 1;
    end
    if (!seen) check("t5_three_words_timeout", 32'(n_wr - start), 32'd3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    q_req.delete();
    q_wr.delete();
    #1 check_all_zero("t5_abort");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (MEM_LAT + 2) @(negedge clk);
    #1;
    check("t5_idle", 32'(fsm_busy), 32'd0);
    check("t5_no_tag", 32'(n_tag - t0), 32'd0);
    run_fill(16'h0104, 16'h0100, 0);
    check("t5_wr_left", 32'(q_wr.size()), 32'd0);

    // 6: back-to-back fills
    repeat (2) @(negedge clk);
    w0 = n_wr;
    t0 = n_tag;
    run_fill(16'h0040, 16'h0040, 0);
    run_fill(16'h2000, 16'h2000, 0);
    repeat (2) @(negedge clk);
    #1;
    check("t6_writes", 32'(n_wr - w0), 32'd16);
    check("t6_tags", 32'(n_tag - t0), 32'd2);
    check("t6_wr_left", 32'(q_wr.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
